// File: rtl/pe_mac_seq.sv
// pe_mac_seq: job sequencer for a single multiply-accumulate PE.
// Clears the PE, streams N operand pairs into it, waits out its pipeline and returns one result per job.
module pe_mac_seq #(
  parameter int W_IN   = 8,
  parameter int LEN_W  = 8,
  parameter int PE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_relu,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W_IN-1:0]  op_a,
  input  logic [W_IN-1:0]  op_b,
  output logic             pe_en,
  output logic             pe_mode_sel,
  output logic             pe_reg_reset,
  output logic [W_IN-1:0]  pe_a,
  output logic [W_IN-1:0]  pe_b,
  input  logic [W_IN-1:0]  pe_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W_IN-1:0]  res_data
);

  localparam int DCNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic              relu_q;
  logic [DCNT_W-1:0] dcnt;
  logic [W_IN-1:0]   res_q;
  logic              op_fire;
  logic              last_term;
  logic              drain_end;

  assign op_fire   = op_valid && op_ready;
  assign last_term = (cnt == len_q - LEN_W'(1));
  assign drain_end = (dcnt == DCNT_W'(PE_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    op_ready     = 1'b0;
    pe_reg_reset = 1'b0;
    pe_mode_sel  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_next = (cfg_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_reg_reset = 1'b1;
        pe_mode_sel  = relu_q;
        state_next   = S_STREAM;
      end
      S_STREAM: begin
        pe_mode_sel = relu_q;
        // cnt < len_q keeps the port closed once every term has been taken
        op_ready    = (cnt < len_q);
        if (op_fire && last_term) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pe_mode_sel = relu_q;
        if (drain_end) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Job bookkeeping and the captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      relu_q <= 1'b0;
      cnt    <= '0;
      dcnt   <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            len_q  <= cfg_len;
            relu_q <= cfg_relu;
            cnt    <= '0;
            dcnt   <= '0;
            if (cfg_len == '0) begin
              res_q <= '0;
            end
          end
        end
        S_STREAM: begin
          dcnt <= '0;
          if (op_fire) begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + DCNT_W'(1);
          // The last term has just reached the PE output on this cycle.
          if (drain_end) begin
            res_q <= pe_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign pe_en     = op_fire;
  assign pe_a      = (state == S_STREAM) ? op_a : '0;
  assign pe_b      = (state == S_STREAM) ? op_b : '0;
  assign res_valid = (state == S_DONE);
  assign res_data  = res_q;

endmodule
